// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH = 2048;
    localparam int unsigned DMEM_AW    = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {
        NORMAL,
        FORCED,
        LOCKED
    } state_t;

    typedef enum logic {
        OWN_P,
        OWN_L
    } owner_t;

    // Word aligned and no address bits set above the word index field.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned aw);
        return ((addr >> (aw + 2)) == 32'd0) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Bus bundle between the MEM stage / loader requesters, the arbiter and the DMem.
interface dmem_if #(
    parameter int unsigned AW = 11
);

    logic          p_req;
    logic          p_we;
    logic [31:0]   p_addr;
    logic [31:0]   p_wdata;
    logic          p_stall;
    logic          p_rvalid;
    logic [31:0]   p_rdata;

    logic          l_req;
    logic          l_we;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;
    logic          l_lock;
    logic          l_gnt;
    logic          l_rvalid;
    logic [31:0]   l_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    logic          addr_err;

    // Arbiter side.
    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_stall, p_rvalid, p_rdata,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        output l_gnt, l_rvalid, l_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output addr_err
    );

    // Requester / memory side.
    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_stall, p_rvalid, p_rdata,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        input  l_gnt, l_rvalid, l_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  addr_err
    );

endinterface

// File: rtl/dmem_addr_check.sv
// Byte address to word index plus range/alignment check.
module dmem_addr_check
    import dmem_pkg::*;
#(
    parameter int unsigned IDX_W = DMEM_AW
) (
    input  logic [31:0]      i_addr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_in_range
);

    assign o_idx      = i_addr[IDX_W+1:2];
    assign o_in_range = addr_ok(i_addr, IDX_W);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMem arbiter: pipeline priority, bounded loader starvation,
// exclusive loader lock, one-cycle read return steered by an owner tag.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH        = DMEM_DEPTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_starve_cnt;
    logic [3:0]    w_starve_nxt;

    logic          w_p_ok;
    logic          w_l_ok;
    logic [AW-1:0] w_p_idx;
    logic [AW-1:0] w_l_idx;
    logic          w_p_gnt;
    logic          w_l_gnt;

    logic          r_tag_valid;
    owner_t        r_tag_who;
    logic          r_tag_err;
    logic          w_p_sel;
    logic          w_l_sel;
    logic [31:0]   w_ret;
    logic [31:0]   w_p_rdata;
    logic [31:0]   w_l_rdata;
    logic [31:0]   r_p_rdata;
    logic [31:0]   r_l_rdata;
    logic          r_addr_err;

    dmem_addr_check #(.IDX_W(AW)) u_p_chk (
        .i_addr     (bus.p_addr),
        .o_idx      (w_p_idx),
        .o_in_range (w_p_ok)
    );

    dmem_addr_check #(.IDX_W(AW)) u_l_chk (
        .i_addr     (bus.l_addr),
        .o_idx      (w_l_idx),
        .o_in_range (w_l_ok)
    );

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= NORMAL;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Grant decision and next state; nothing is granted while in reset.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_p_gnt      = 1'b0;
        w_l_gnt      = 1'b0;
        if (!reset) begin
            unique case (r_state)
                NORMAL: begin
                    if (bus.p_req) begin
                        w_p_gnt = 1'b1;
                        if (bus.l_req) begin
                            // Counter value after this losing cycle reaching LIMIT-1 forces the next slot.
                            w_starve_nxt = r_starve_cnt + 4'd1;
                            if (r_starve_cnt >= LIMIT_M1 - 4'd1 || LIMIT_M1 == 4'd0) begin
                                w_state_nxt = FORCED;
                            end
                        end
                    end else if (bus.l_req) begin
                        w_l_gnt      = 1'b1;
                        w_starve_nxt = '0;
                        if (bus.l_lock) begin
                            w_state_nxt = LOCKED;
                        end
                    end
                end
                FORCED: begin
                    w_l_gnt     = bus.l_req;
                    w_state_nxt = NORMAL;
                    if (bus.l_req) begin
                        w_starve_nxt = '0;
                    end
                end
                LOCKED: begin
                    w_l_gnt = bus.l_req;
                    if (bus.l_req) begin
                        w_starve_nxt = '0;
                    end
                    if (!bus.l_lock) begin
                        w_state_nxt = NORMAL;
                    end
                end
                default: w_state_nxt = NORMAL;
            endcase
        end
    end

    // Memory port driven from the winner; out-of-range accesses never enable it.
    always_comb begin
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (w_p_gnt) begin
            bus.m_en    = w_p_ok;
            bus.m_we    = bus.p_we && w_p_ok;
            bus.m_addr  = w_p_idx;
            bus.m_wdata = bus.p_wdata;
        end else if (w_l_gnt) begin
            bus.m_en    = w_l_ok;
            bus.m_we    = bus.l_we && w_l_ok;
            bus.m_addr  = w_l_idx;
            bus.m_wdata = bus.l_wdata;
        end
    end

    assign bus.p_stall = bus.p_req && !w_p_gnt && !reset;
    assign bus.l_gnt   = w_l_gnt;

    // Owner tag for the read response due next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_valid <= 1'b0;
            r_tag_who   <= OWN_P;
            r_tag_err   <= 1'b0;
        end else begin
            r_tag_valid <= (w_p_gnt && !bus.p_we) || (w_l_gnt && !bus.l_we);
            r_tag_who   <= w_p_gnt ? OWN_P : OWN_L;
            r_tag_err   <= w_p_gnt ? !w_p_ok : !w_l_ok;
        end
    end

    // Read return: owner sees memory data (or 0 for a suppressed access), the other port holds.
    always_comb begin
        w_p_sel   = r_tag_valid && (r_tag_who == OWN_P) && !reset;
        w_l_sel   = r_tag_valid && (r_tag_who == OWN_L) && !reset;
        w_ret     = r_tag_err ? '0 : bus.m_rdata;
        w_p_rdata = reset ? '0 : (w_p_sel ? w_ret : r_p_rdata);
        w_l_rdata = reset ? '0 : (w_l_sel ? w_ret : r_l_rdata);
    end

    assign bus.p_rvalid = w_p_sel;
    assign bus.l_rvalid = w_l_sel;
    assign bus.p_rdata  = w_p_rdata;
    assign bus.l_rdata  = w_l_rdata;

    // Hold registers for the last read data presented on each port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_rdata <= '0;
            r_l_rdata <= '0;
        end else begin
            r_p_rdata <= w_p_rdata;
            r_l_rdata <= w_l_rdata;
        end
    end

    // Sticky flag for any suppressed out-of-range access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if ((w_p_gnt && !w_p_ok) || (w_l_gnt && !w_l_ok)) begin
            r_addr_err <= 1'b1;
        end
    end

    assign bus.addr_err = r_addr_err && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    dmem_if #(.AW(11)) bus ();

    dmem_arbiter #(.DEPTH(2048), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:2047];
    logic [31:0] mem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
            else          mem_rdata       <= mem[bus.m_addr];
        end
    end
    assign bus.m_rdata = mem_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_lock = 0;
        tick();
        tick();
        // requests present during reset must not be granted
        bus.p_req = 1; bus.l_req = 1;
        #1;
        chk("rst_lgnt",   bus.l_gnt,    0);
        chk("rst_pstall", bus.p_stall,  0);
        chk("rst_men",    bus.m_en,     0);
        chk("rst_prv",    bus.p_rvalid, 0);
        chk("rst_lrv",    bus.l_rvalid, 0);
        chk("rst_err",    bus.addr_err, 0);
        bus.p_req = 0; bus.l_req = 0;
        tick();
        reset = 1'b0;
        chk("rst_prdata", bus.p_rdata, 0);
        chk("rst_lrdata", bus.l_rdata, 0);
        tick();

        // preload through the loader
        bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h10; bus.l_wdata = 32'hDEADBEEF;
        #1;
        chk("pre_lgnt",  bus.l_gnt,  1);
        chk("pre_mwe",   bus.m_we,   1);
        chk("pre_maddr", 32'(bus.m_addr), 4);
        tick();
        bus.l_addr = 32'h8; bus.l_wdata = 32'hA5A50008;
        tick();
        bus.l_addr = 32'hC; bus.l_wdata = 32'h5A5A000C;
        tick();

        // basic pipeline read
        bus.l_req = 0; bus.l_we = 0;
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h10;
        #1;
        chk("rd_maddr",  32'(bus.m_addr), 4);
        chk("rd_men",    bus.m_en,    1);
        chk("rd_pstall", bus.p_stall, 0);
        tick();
        bus.p_req = 0;
        #1;
        chk("rd_prv",    bus.p_rvalid, 1);
        chk("rd_prdata", bus.p_rdata,  32'hDEADBEEF);
        chk("rd_lrv",    bus.l_rvalid, 0);
        tick();

        // starvation bound: loader forced every 4th cycle
        for (int k = 1; k <= 8; k++) begin
            bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h10;
            bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'hC;
            #1;
            chk("stv_lgnt",   bus.l_gnt,   32'((k % 4) == 0));
            chk("stv_pstall", bus.p_stall, 32'((k % 4) == 0));
            if (k >= 2) begin
                prev = ((k - 1) % 4) == 0;
                chk("stv_lrv", bus.l_rvalid, 32'(prev));
                chk("stv_prv", bus.p_rvalid, 32'(!prev));
                if (prev) chk("stv_lrdata", bus.l_rdata, 32'h5A5A000C);
                else      chk("stv_prdata", bus.p_rdata, 32'hDEADBEEF);
            end
            tick();
        end
        bus.p_req = 0; bus.l_req = 0;
        #1;
        chk("stv_last_lrv", bus.l_rvalid, 1);
        tick();

        // alternating owners every cycle
        for (int j = 0; j < 6; j++) begin
            if (j % 2 == 0) begin
                bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h8; bus.l_req = 0;
            end else begin
                bus.p_req = 0; bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'hC;
            end
            #1;
            chk("alt_lgnt", bus.l_gnt, 32'(j % 2));
            if (j == 0) begin
                chk("alt_prv0", bus.p_rvalid, 0);
                chk("alt_lrv0", bus.l_rvalid, 0);
            end else begin
                prev = ((j - 1) % 2) == 0;
                chk("alt_prv", bus.p_rvalid, 32'(prev));
                chk("alt_lrv", bus.l_rvalid, 32'(!prev));
                if (prev) chk("alt_prdata", bus.p_rdata, 32'hA5A50008);
                else      chk("alt_lrdata", bus.l_rdata, 32'h5A5A000C);
            end
            tick();
        end
        bus.p_req = 0; bus.l_req = 0;
        #1;
        chk("alt_last_lrv", bus.l_rvalid, 1);
        chk("alt_last_prv", bus.p_rvalid, 0);
        tick();

        // exclusive loader lock
        for (int i = 0; i < 8; i++) begin
            bus.l_lock = 1; bus.l_req = 1; bus.l_we = 1;
            bus.l_addr = 32'(4 * i); bus.l_wdata = 32'h11110000 + 32'(i);
            bus.p_req = (i != 0); bus.p_we = 0; bus.p_addr = 32'h10;
            #1;
            chk("lck_lgnt",   bus.l_gnt,   1);
            chk("lck_pstall", bus.p_stall, 32'(i != 0));
            chk("lck_maddr",  32'(bus.m_addr), 32'(i));
            chk("lck_mwe",    bus.m_we,    1);
            tick();
        end
        bus.l_lock = 0; bus.l_req = 0; bus.l_we = 0;
        #1;
        chk("unl_pstall", bus.p_stall, 1);
        chk("unl_lgnt",   bus.l_gnt,   0);
        tick();
        #1;
        chk("unl_pgnt",  bus.p_stall, 0);
        chk("unl_maddr", 32'(bus.m_addr), 4);
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.p_addr = 32'(4 * i);
            #1;
            chk("rb_prv", bus.p_rvalid, 1);
            if (i == 0) chk("rb_prdata", bus.p_rdata, 32'h11110004);
            else        chk("rb_prdata", bus.p_rdata, 32'h11110000 + 32'(i - 1));
            tick();
        end
        bus.p_req = 0;
        #1;
        chk("rb_last", bus.p_rdata, 32'h11110007);
        tick();

        // out-of-range store and misaligned read
        chk("err_pre", bus.addr_err, 0);
        bus.p_req = 1; bus.p_we = 1; bus.p_addr = 32'h2000; bus.p_wdata = 32'hCAFE0000;
        #1;
        chk("oob_men",    bus.m_en,    0);
        chk("oob_pstall", bus.p_stall, 0);
        tick();
        bus.p_req = 0; bus.p_we = 0;
        #1;
        chk("oob_err", bus.addr_err, 1);
        chk("oob_prv", bus.p_rvalid, 0);
        tick();
        chk("oob_sticky", bus.addr_err, 1);
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h6;
        #1;
        chk("mis_men",    bus.m_en,    0);
        chk("mis_pstall", bus.p_stall, 0);
        tick();
        bus.p_req = 0;
        #1;
        chk("mis_prv",    bus.p_rvalid, 1);
        chk("mis_prdata", bus.p_rdata,  0);
        tick();

        // reset right after a loader read grant drops the response
        bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'hC;
        #1;
        chk("rr_lgnt", bus.l_gnt, 1);
        tick();
        bus.l_req = 0;
        reset = 1'b1;
        #1;
        chk("rr_lrv",    bus.l_rvalid, 0);
        chk("rr_lrdata", bus.l_rdata,  0);
        chk("rr_err",    bus.addr_err, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rr_err_post", bus.addr_err, 0);
        chk("rr_lrv_post", bus.l_rvalid, 0);
        // fresh counter in NORMAL: loader forced on the 4th contended cycle
        for (int k = 1; k <= 4; k++) begin
            bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h10;
            bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'hC;
            #1;
            chk("rr_stv_lgnt", bus.l_gnt, 32'(k == 4));
            tick();
        end
        bus.p_req = 0; bus.l_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port 2048-word data memory between the pipeline MEM stage and a loader/debug port. Grants one access per cycle and stalls the pipeline when the loader wins. Bounds loader starvation and supports an exclusive loader lock for program/data preload. Sits between the MEM stage and the DMem instance.

Parameters:
DEPTH, 2048, memory words (index width AW = $clog2(DEPTH) = 11)
STARVE_LIMIT, 4, consecutive loader-wait cycles before a forced loader slot (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
p_req  in  1  pipeline access request (MEM stage load/store)
p_we  in  1  pipeline write enable
p_addr  in  32  pipeline byte address
p_wdata  in  32  pipeline store data
p_stall  out  1  pipeline access not granted this cycle; hold MEM stage
p_rvalid  out  1  pipeline read data valid (cycle after grant)
p_rdata  out  32  pipeline read data
l_req  in  1  loader request
l_we  in  1  loader write enable
l_addr  in  32  loader byte address
l_wdata  in  32  loader write data
l_lock  in  1  loader requests exclusive ownership
l_gnt  out  1  loader access granted this cycle
l_rvalid  out  1  loader read data valid
l_rdata  out  32  loader read data
m_en  out  1  memory enable
m_we  out  1  memory write enable
m_addr  out  AW  memory word index
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data, valid one cycle after m_en && !m_we
addr_err  out  1  sticky: an out-of-range access was suppressed

Behaviour:
- Word index = addr[AW+1:2]. Out of range when addr[31:AW+2] != 0 or addr[1:0] != 0.
- Out-of-range access is granted (handshake completes) but m_en is held 0. A read returns 0 with rvalid. addr_err sets and stays set until reset.
- Grant logic is combinational from state/counter/requests. m_* outputs are combinational from the winner.
- FSM states:
  - NORMAL: pipeline has priority.
    - p_req wins. l_req alone wins.
    - Each cycle l_req is pending and losing, starve_cnt += 1; starve_cnt clears when the loader is granted.
    - starve_cnt == STARVE_LIMIT-1 while losing -> FORCED.
    - l_lock && l_req && no pipeline grant this cycle -> LOCKED.
  - FORCED: loader granted if l_req. p_stall = p_req. Next state is NORMAL, unconditionally; if l_req dropped, the slot is wasted.
  - LOCKED: loader always wins. p_stall = p_req. Stays LOCKED while l_lock; l_lock low -> NORMAL.
- p_stall = p_req && !pipeline_grant. p_stall is never asserted when p_req = 0.
- Read latency is exactly 1 cycle. A registered owner tag (valid, who, err) steers m_rdata to p_rdata or l_rdata next cycle. The non-owner rdata output holds its last value; its rvalid is 0.
- Writes produce no rvalid.
- Back-to-back grants to alternating owners are legal every cycle.
- Simultaneous p_req and l_req in NORMAL below the limit: pipeline wins, loader waits (l_gnt = 0, request must be held).
- Reset mid-operation:
  - state = NORMAL, starve_cnt = 0, owner tag cleared.
  - p_rvalid = l_rvalid = 0, p_rdata = l_rdata = 0, addr_err = 0.
  - Combinational outputs are 0 during reset: m_en, m_we, l_gnt, p_stall.
  - An in-flight read response is dropped.

Decomposition:
- Shared package dmem_pkg: state enum (NORMAL, FORCED, LOCKED), owner enum (OWN_P, OWN_L), DEPTH/AW constants, addr_ok() function.
- One sub-module, dmem_addr_check: byte address -> {word index, in_range}. Instantiated once per requester.

Test Plan:
- Reset, then pipeline read of 0x0000_0010 with mem[4] = 0xDEADBEEF -> m_addr = 4 in cycle 0; p_rvalid = 1, p_rdata = 0xDEADBEEF in cycle 1; p_stall = 0.
- p_req and l_req held continuously, STARVE_LIMIT = 4 -> l_gnt = 0 for 3 cycles, then l_gnt = 1 and p_stall = 1 in cycle 4; pipeline granted in cycle 5; pattern repeats.
- l_lock = 1 with l_req, writing 0x1111_0000+i to addresses 4*i for i = 0..7 while p_req = 1 -> p_stall = 1 throughout; l_lock drop -> pipeline granted next cycle; readback matches.
- Pipeline store to 0x0000_2000 (index 2048, out of range) -> m_en = 0, no stall, addr_err = 1 and sticky. Misaligned read at 0x0000_0006 -> p_rvalid = 1, p_rdata = 0.
- Alternating pipeline read (addr 0x8) and loader read (addr 0xC) every cycle -> rvalid and rdata arrive on the correct port each next cycle; no crossover.
- reset asserted the cycle after a loader read grant -> l_rvalid stays 0, state NORMAL, starve_cnt = 0, addr_err = 0.
